// File: rtl/boot_loader.sv
// boot_loader: receives a program over an 8N1 UART and writes it to
// instruction memory one 32-bit word at a time. The first two bytes carry
// the word count N (little-endian), followed by 4*N little-endian data bytes.
// The processor is held in reset until the whole program has been written.
`timescale 1ns/1ps
module boot_loader #(
    parameter int          CLKS_PER_BIT = 104,
    parameter int          MAX_WORDS    = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic        write_mem,
    output logic [31:0] write_address,
    output logic [31:0] write_data,
    output logic [2:0]  funct3,
    output logic        core_rst_n,
    output logic        done,
    output logic        error
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    // Bit-timer width; at least one bit so tiny CLKS_PER_BIT still elaborates.
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    // Last count of a full bit period and of the half period used to
    // re-check the start bit in its middle.
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    // Largest accepted word count, widened so the compare never truncates.
    localparam logic [31:0] MAX_N32 = 32'(MAX_WORDS);

    // Every write is a full 32-bit word store.
    localparam logic [2:0] FUNCT3_WORD = 3'b010;

    // ------------------------------------------------------------------
    // Receiver state
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    logic             r_rx_meta;
    logic             r_rx_sync;
    logic             r_rx_prev;
    rx_state_t        r_rx_state;
    logic [CNT_W-1:0] r_rx_cnt;
    logic [2:0]       r_rx_bit_idx;
    logic [7:0]       r_rx_shift;
    logic             r_byte_valid;
    logic             r_frame_err;

    // ------------------------------------------------------------------
    // Controller state
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        DONE,
        ERROR
    } state_t;

    state_t      r_state;
    logic [15:0] r_len;
    logic [15:0] r_word_idx;
    logic [1:0]  r_byte_cnt;
    logic [23:0] r_word;
    logic        r_write_mem;
    logic [31:0] r_write_address;
    logic [31:0] r_write_data;
    logic [2:0]  r_funct3;
    logic        r_core_rst_n;
    logic        r_done;
    logic        r_error;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic        w_data_byte;
    logic [3:0]  w_lane_hit;
    logic [15:0] w_len_full;
    logic [31:0] w_word_full;
    logic [15:0] w_idx_next;
    logic [31:0] w_word_addr;
    logic        w_len_too_big;

    // A byte belongs to the program image only while collecting data.
    assign w_data_byte = r_byte_valid && (r_state == DATA);

    // One-hot lane select: which byte of the current word this byte fills.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane_hit[gi] = w_data_byte && (r_byte_cnt == 2'(gi));
        end
    endgenerate

    assign w_len_full    = {r_rx_shift, r_len[7:0]};
    assign w_word_full   = {r_rx_shift, r_word};
    assign w_idx_next    = r_word_idx + 16'd1;
    assign w_word_addr   = BASE_ADDR + {14'b0, r_word_idx, 2'b00};
    assign w_len_too_big = ({16'b0, w_len_full} > MAX_N32);

    // ------------------------------------------------------------------
    // Outputs come straight from registers
    // ------------------------------------------------------------------
    assign write_mem     = r_write_mem;
    assign write_address = r_write_address;
    assign write_data    = r_write_data;
    assign funct3        = r_funct3;
    assign core_rst_n    = r_core_rst_n;
    assign done          = r_done;
    assign error         = r_error;

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // UART receiver: start detect, mid-start glitch filter, 8 data bits
    // LSB first, stop-bit check; byte_valid / frame_err are one-cycle pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_state   <= RX_IDLE;
            r_rx_cnt     <= '0;
            r_rx_bit_idx <= 3'd0;
            r_rx_shift   <= 8'd0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    r_rx_cnt <= '0;
                    if (r_rx_prev && !r_rx_sync) begin
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == HALF_LAST) begin
                        r_rx_cnt     <= '0;
                        r_rx_bit_idx <= 3'd0;
                        // A line already back high mid-start was only a glitch.
                        r_rx_state   <= r_rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                        if (r_rx_bit_idx == 3'd7) begin
                            r_rx_state <= RX_STOP;
                        end else begin
                            r_rx_bit_idx <= r_rx_bit_idx + 3'd1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt     <= '0;
                        r_rx_state   <= RX_IDLE;
                        r_byte_valid <= r_rx_sync;
                        r_frame_err  <= !r_rx_sync;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_rx_state <= RX_IDLE;
                end
            endcase
        end
    end

    // Load controller: length header, word assembly, one-cycle memory write,
    // and the terminal DONE / ERROR states with their registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= LEN_LO;
            r_len           <= 16'd0;
            r_word_idx      <= 16'd0;
            r_byte_cnt      <= 2'd0;
            r_word          <= 24'd0;
            r_write_mem     <= 1'b0;
            r_write_address <= 32'd0;
            r_write_data    <= 32'd0;
            r_funct3        <= FUNCT3_WORD;
            r_core_rst_n    <= 1'b0;
            r_done          <= 1'b0;
            r_error         <= 1'b0;
        end else begin
            r_write_mem <= 1'b0;
            if (r_frame_err && (r_state != DONE) && (r_state != ERROR)) begin
                // A corrupted byte anywhere in the load aborts it for good.
                r_state      <= ERROR;
                r_error      <= 1'b1;
                r_done       <= 1'b0;
                r_core_rst_n <= 1'b0;
            end else begin
                case (r_state)
                    LEN_LO: begin
                        if (r_byte_valid) begin
                            r_len[7:0] <= r_rx_shift;
                            r_state    <= LEN_HI;
                        end
                    end
                    LEN_HI: begin
                        if (r_byte_valid) begin
                            r_len      <= w_len_full;
                            r_word_idx <= 16'd0;
                            r_byte_cnt <= 2'd0;
                            if (w_len_full == 16'd0) begin
                                // Empty program: release the core at once.
                                r_state      <= DONE;
                                r_done       <= 1'b1;
                                r_core_rst_n <= 1'b1;
                            end else if (w_len_too_big) begin
                                r_state <= ERROR;
                                r_error <= 1'b1;
                            end else begin
                                r_state <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        for (int k = 0; k < 3; k++) begin
                            if (w_lane_hit[k]) begin
                                r_word[8*k +: 8] <= r_rx_shift;
                            end
                        end
                        if (w_data_byte) begin
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                        end
                        if (w_lane_hit[3]) begin
                            // Fourth byte completes the word: present it next cycle.
                            r_write_mem     <= 1'b1;
                            r_write_address <= w_word_addr;
                            r_write_data    <= w_word_full;
                            r_funct3        <= FUNCT3_WORD;
                            r_state         <= WRITE;
                        end
                    end
                    WRITE: begin
                        r_word_idx <= w_idx_next;
                        if (w_idx_next == r_len) begin
                            r_state      <= DONE;
                            r_done       <= 1'b1;
                            r_core_rst_n <= 1'b1;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                    DONE: begin
                        // Program loaded; further UART traffic is ignored.
                        r_state <= DONE;
                    end
                    ERROR: begin
                        // Only reset leaves this state.
                        r_state <= ERROR;
                    end
                    default: begin
                        r_state      <= ERROR;
                        r_error      <= 1'b1;
                        r_done       <= 1'b0;
                        r_core_rst_n <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 104, meaning the number of clk cycles per UART bit (12 MHz / 115200).
REQ-002 The block SHALL have parameter MAX_WORDS, default 1024, meaning the largest accepted program length in 32-bit words.
REQ-003 The block SHALL have parameter BASE_ADDR, default 32'h0, meaning the byte address of the first loaded word.
REQ-004 The block SHALL have one clock and one reset: the reset is asynchronous and active-high.
REQ-005 The ports SHALL be as follows:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- uart_rx  in  1  serial input, 8N1, idle high.
- write_mem  out  1  one-cycle memory write strobe.
- write_address  out  32  byte address of the word being written.
- write_data  out  32  assembled instruction word.
- funct3  out  3  memory access size for the write.
- core_rst_n  out  1  active-low hold of the processor; 0 while loading.
- done  out  1  load completed.
- error  out  1  protocol or framing fault.

Function
REQ-006 uart_rx SHALL pass through a 2-flop synchronizer before any use.
REQ-007 The receiver SHALL detect a start bit on a synchronized high-to-low transition.
REQ-008 The receiver SHALL re-check the start bit at CLKS_PER_BIT/2 and return to idle if the line is high there (glitch).
REQ-009 The receiver SHALL sample 8 data bits, LSB first, each CLKS_PER_BIT cycles after the previous sample point.
REQ-010 The receiver SHALL sample the stop bit one bit-time after the 8th data bit; a low stop bit is a framing error.
REQ-011 Each received byte SHALL produce a one-cycle internal byte_valid pulse, issued at the stop-bit sample.
REQ-012 The controller FSM SHALL have states LEN_LO, LEN_HI, DATA, WRITE, DONE and ERROR.
REQ-013 The FSM SHALL leave reset in LEN_LO.
REQ-014 In LEN_LO, the first byte SHALL become N[7:0]; the FSM then goes to LEN_HI.
REQ-015 In LEN_HI, the next byte SHALL become N[15:8]. The next state is:
- DONE if N==0.
- ERROR if N>MAX_WORDS.
- DATA otherwise.
REQ-016 In DATA, bytes SHALL be assembled little-endian: byte k of a word goes to bits [8k+7:8k], for k=0..3.
REQ-017 After the 4th byte of a word, the FSM SHALL enter WRITE for exactly one cycle.
REQ-018 In WRITE, the block SHALL assert write_mem=1, funct3=3'b010, write_address=BASE_ADDR+4*word_idx and write_data=the assembled word.
REQ-019 Memory write latency SHALL be 1 cycle after the 4th byte_valid.
REQ-020 After WRITE, word_idx SHALL increment. The FSM then goes to DONE if word_idx+1==N, and back to DATA otherwise.
REQ-021 word_idx SHALL be 16 bits and SHALL never wrap, because N<=MAX_WORDS is enforced.
REQ-022 Outside WRITE, write_mem SHALL be 0; write_address and write_data SHALL hold their last values.
REQ-023 In DONE, the block SHALL drive done=1 and core_rst_n=1 (core released), and SHALL ignore all further UART bytes.
REQ-024 A framing error in any state other than DONE SHALL force ERROR.
REQ-025 In ERROR, the block SHALL drive error=1 and core_rst_n=0. ERROR SHALL be left only by rst.
REQ-026 No timeout SHALL apply between bytes; a partial word SHALL wait indefinitely.
REQ-027 done and error SHALL never be 1 simultaneously.
REQ-028 core_rst_n SHALL change only on clk edges, except on assertion of rst.

Reset
REQ-029 rst SHALL take effect immediately, asynchronously, and force these values:
- FSM=LEN_LO, with the receiver idle.
- write_mem=0, write_address=0, write_data=0, funct3=3'b010.
- core_rst_n=0, done=0, error=0.
- word_idx=0, N=0, and the byte counter=0.
REQ-030 Assertion of rst mid-byte or mid-load SHALL discard partial data. The next byte after rst deassertion SHALL be treated as N[7:0].

Verification
REQ-031 The bench SHALL send N=2, then words 32'h00500093 and 32'h00A00113 as 8 LE bytes. Required response:
- write at 0x0 with 0x00500093, then a write at 0x4 with 0x00A00113.
- done=1 and core_rst_n=1 after the 2nd write.
REQ-032 The bench SHALL send N=0 (bytes 00 00). Required response: DONE immediately after the 2nd byte, no write_mem pulse, core_rst_n=1.
REQ-033 The bench SHALL send N=1025 (bytes 01 04). Required response: error=1, core_rst_n=0, and no writes for any later bytes.
REQ-034 The bench SHALL send a byte whose stop bit is held low during DATA. Required response: error=1, and no write for the partial word.
REQ-035 The bench SHALL apply a low pulse on uart_rx shorter than CLKS_PER_BIT/2. Required response: no byte_valid and the FSM state unchanged.
REQ-036 The bench SHALL assert rst after 2 data bytes of word 0, then send a full N=1 load of 32'hDEADBEEF. Required response: a single write at 0x0 with 0xDEADBEEF, then done=1.
